// File: rtl/sdiv_pkg.sv
// Shared definitions for the iterative signed-division sequencer.
// Holds the FSM state encoding and the default operand sizing.
package sdiv_pkg;

  localparam int SDIV_DATA_W = 8;
  localparam int SDIV_CNT_W  = 4;

  localparam logic [SDIV_DATA_W-1:0] MIN_VAL = SDIV_DATA_W'(1 << (SDIV_DATA_W - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep the difference only if non-negative.
module sdiv_step
  import sdiv_pkg::*;
#(
  parameter int DATA_W = SDIV_DATA_W
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_msb,
  input  logic [DATA_W-1:0] i_dmag,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_dmag};
  assign o_qbit  = (w_shift >= {1'b0, i_dmag});
  // The kept value is always below the divisor magnitude, so it fits DATA_W bits.
  assign o_rem   = DATA_W'(o_qbit ? w_diff : w_shift);

endmodule

// File: rtl/sdiv_ctrl.sv
// Non-pipelined signed-division sequencer: IDLE -> PREP -> ITER -> FIX -> IDLE.
// Works on magnitudes, then restores signs so quotient truncates toward zero.
//   state | meaning
//   IDLE  | waiting for start, results held
//   PREP  | take magnitudes and signs, arm counter
//   ITER  | DATA_W restoring steps
//   FIX   | apply signs and special cases, pulse done
module sdiv_ctrl
  import sdiv_pkg::*;
#(
  parameter int DATA_W = SDIV_DATA_W,
  parameter int CNT_W  = SDIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_W    = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_dvd, r_dvs, r_q, r_rem, r_dmag;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign_q, r_sign_r, r_zero;
  logic              r_busy, r_done, r_dz, r_ovf;
  logic [DATA_W-1:0] r_quot, r_remo;
  logic [DATA_W-1:0] w_dvd_mag, w_dvs_mag, w_rem_next;
  logic              w_qbit;

  assign w_dvd_mag = r_dvd[DATA_W-1] ? -r_dvd : r_dvd;
  assign w_dvs_mag = r_dvs[DATA_W-1] ? -r_dvs : r_dvs;

  sdiv_step #(.DATA_W(DATA_W)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_q[DATA_W-1]),
    .i_dmag (r_dmag),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PREP;
      S_PREP:  w_next = (r_dvs == '0) ? S_FIX : S_ITER;
      S_ITER:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_dmag   <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_quot   <= '0;
      r_remo   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_busy <= 1'b1;
          end
        end
        S_PREP: begin
          r_sign_q <= r_dvd[DATA_W-1] ^ r_dvs[DATA_W-1];
          r_sign_r <= r_dvd[DATA_W-1];
          r_q      <= w_dvd_mag;
          r_dmag   <= w_dvs_mag;
          r_rem    <= '0;
          r_cnt    <= CNT_LAST;
          r_zero   <= (r_dvs == '0);
        end
        S_ITER: begin
          r_q   <= {r_q[DATA_W-2:0], w_qbit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dz   <= r_zero;
          // MIN / -1 needs no special arithmetic: the magnitude wraps back to MIN.
          r_ovf  <= !r_zero && (r_dvd == MIN_W) && (r_dvs == '1);
          if (r_zero) begin
            r_quot <= '1;
            r_remo <= r_dvd;
          end else begin
            r_quot <= r_sign_q ? -r_q : r_q;
            r_remo <= r_sign_r ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dz;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_sdiv_ctrl.sv
// Self-checking bench for sdiv_ctrl: timeline model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_sdiv_ctrl;
  import sdiv_pkg::*;

  localparam int W = SDIV_DATA_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdiv_ctrl #(.DATA_W(W), .CNT_W(SDIV_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the division rules.
  task automatic model_div(input logic [W-1:0] d_in, input logic [W-1:0] s_in,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output logic ov);
    int a, b;
    a = int'($signed(d_in));
    b = int'($signed(s_in));
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = d_in;
      dz = 1'b1;
    end else if (d_in == MIN_VAL && b == -1) begin
      q  = MIN_VAL;
      r  = '0;
      ov = 1'b1;
    end else begin
      q = W'(a / b);
      r = W'(a % b);
    end
  endtask

  // Timeline model: an accepted op publishes its results a fixed number of edges later.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_ov = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic [W-1:0] p_q, p_r;
  logic         p_dz, p_ov;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_ov = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = (divisor == '0) ? 2 : W + 2;
        model_div(dividend, divisor, p_q, p_r, p_dz, p_ov);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc quotient", quotient, m_q);
      chk("cyc remainder", remainder, m_r);
      chk("cyc div_zero", div_zero, m_dz);
      chk("cyc overflow", overflow, m_ov);
    end
  end

  // Called at a negedge; start is seen by the next rising edge.
  task automatic run(input string nm, input logic [W-1:0] d_in, input logic [W-1:0] s_in,
                     input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input logic eov);
    int lat;
    start = 1'b1; dividend = d_in; divisor = s_in;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0; dividend = 8'hA5; divisor = 8'h00;
      lat++;
    end while (!done && lat < 40);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " div_zero"}, div_zero, edz);
    chk({nm, " overflow"}, overflow, eov);
  endtask

  int lat2;

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);

    run("5/2",    8'd5,  8'd2,  11, 8'h02, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    run("-7/2",   8'hF9, 8'd2,  11, 8'hFD, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    run("7/-2",   8'd7,  8'hFE, 11, 8'hFD, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    run("min/-1", 8'h80, 8'hFF, 11, 8'h80, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    run("5/0",    8'd5,  8'd0,  3,  8'hFF, 8'h05, 1'b1, 1'b0);
    @(negedge clk);
    run("-128/7", 8'h80, 8'd7,  11, 8'hEE, 8'hFE, 1'b0, 1'b0);

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd5; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    lat2 = 1;
    repeat (2) begin @(negedge clk); lat2++; end
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0; lat2++;
    while (!done && lat2 < 40) begin @(negedge clk); lat2++; end
    chk("ignore latency", lat2, 11);
    chk("ignore quotient", quotient, 8'h02);
    chk("ignore remainder", remainder, 8'h01);

    // back-to-back: start issued in the done cycle
    run("b2b 9/3", 8'd9, 8'd3, 11, 8'h03, 8'h00, 1'b0, 1'b0);

    // asynchronous reset in the middle of ITER
    @(negedge clk);
    start = 1'b1; dividend = 8'hF9; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    chk("async quotient", quotient, 0);
    chk("async remainder", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run("post-rst 5/2", 8'd5, 8'd2, 11, 8'h02, 8'h01, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
